// File: rtl/fc1_lif_neuron_layer.sv
// rtl/fc1_lif_neuron_layer.sv - leaky integrate-and-fire layer behind FC1, one neuron per cycle
// Captures FC1 currents, sweeps all membranes through one shared multiplier, emits spikes and counts.
module fc1_lif_neuron_layer #(
   parameter int                      WIDTH   = 24,
   parameter int                      FRAC    = 17,
   parameter int                      NEURONS = 20,
   parameter logic signed [WIDTH-1:0] BETA    = 24'h1C000,
   parameter logic signed [WIDTH-1:0] VTH     = 24'h20000,
   parameter int                      CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [WIDTH*NEURONS-1:0]   cur_in,
   input  logic                       clear_mem,
   output logic                       busy,
   output logic                       spike_valid,
   output logic [NEURONS-1:0]         spikes,
   output logic [WIDTH*NEURONS-1:0]   v_mem,
   output logic [CNT_W*NEURONS-1:0]   spike_cnt,
   output logic                       overrun
);
   localparam int KW = $clog2(NEURONS);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

   state_t                  state_q;
   logic [KW-1:0]           k_q;
   logic signed [WIDTH-1:0] cur_q [NEURONS];
   logic signed [WIDTH-1:0] v_q   [NEURONS];
   logic [CNT_W-1:0]        cnt_q [NEURONS];
   logic [NEURONS-1:0]      spikes_q;
   logic                    busy_q;
   logic                    spike_valid_q;
   logic                    overrun_q;

   logic signed [WIDTH-1:0]   v_sel;
   logic signed [WIDTH-1:0]   cur_sel;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [2*WIDTH-1:0] leak_full;
   logic signed [WIDTH:0]     sum;
   logic signed [WIDTH-1:0]   sat;
   logic                      fire;
   logic signed [WIDTH-1:0]   v_d;
   logic [CNT_W-1:0]          cnt_d;
   logic                      unused_leak_hi;

   assign v_sel     = v_q[k_q];
   assign cur_sel   = cur_q[k_q];
   assign prod      = (2*WIDTH)'(v_sel) * (2*WIDTH)'(BETA);
   assign leak_full = prod >>> FRAC;
   // With BETA <= 1.0 the leaked value always fits in WIDTH bits, so only the low WIDTH+1 bits matter.
   assign sum       = leak_full[WIDTH:0] + {cur_sel[WIDTH-1], cur_sel};
   assign unused_leak_hi = ^leak_full[2*WIDTH-1:WIDTH+1];

   always_comb begin
      sat = sum[WIDTH-1:0];
      if (sum[WIDTH] != sum[WIDTH-1])
         sat = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   assign fire  = (sat >= VTH);
   assign v_d   = fire ? sat - VTH : sat;
   assign cnt_d = (fire && cnt_q[k_q] != '1) ? cnt_q[k_q] + 1'b1 : cnt_q[k_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         k_q           <= '0;
         spikes_q      <= '0;
         busy_q        <= 1'b0;
         spike_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         for (int i = 0; i < NEURONS; i++) begin
            cur_q[i] <= '0;
            v_q[i]   <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         spike_valid_q <= 1'b0;
         if (in_valid && !clear_mem && state_q != S_IDLE)
            overrun_q <= 1'b1;
         if (clear_mem) begin
            for (int i = 0; i < NEURONS; i++) begin
               v_q[i]   <= '0;
               cnt_q[i] <= '0;
            end
            spikes_q <= '0;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
         end
         // A clear in the same idle cycle zeroes the membranes first, so the sweep starts from v = 0.
         if (state_q == S_IDLE && in_valid) begin
            for (int i = 0; i < NEURONS; i++)
               cur_q[i] <= cur_in[i*WIDTH +: WIDTH];
            k_q     <= '0;
            state_q <= S_UPDATE;
            busy_q  <= 1'b1;
         end else if (!clear_mem) begin
            case (state_q)
               S_UPDATE: begin
                  v_q[k_q]      <= v_d;
                  cnt_q[k_q]    <= cnt_d;
                  spikes_q[k_q] <= fire;
                  if (k_q == KW'(NEURONS-1)) begin
                     state_q       <= S_DONE;
                     spike_valid_q <= 1'b1;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NEURONS; g++) begin : g_out
      assign v_mem[g*WIDTH +: WIDTH]     = v_q[g];
      assign spike_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   assign busy        = busy_q;
   assign spike_valid = spike_valid_q;
   assign spikes      = spikes_q;
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_fc1_lif_neuron_layer.sv
// tb/tb_fc1_lif_neuron_layer.sv - scoreboard bench for the FC1 LIF layer
// Expected timestep results come from an integer model and are compared when spike_valid pulses.
module tb_fc1_lif_neuron_layer;
   localparam int W = 24;
   localparam int N = 20;
   localparam int C = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic [W*N-1:0]   cur_in = '0;
   logic             clear_mem = 1'b0;
   logic             busy;
   logic             spike_valid;
   logic [N-1:0]     spikes;
   logic [W*N-1:0]   v_mem;
   logic [C*N-1:0]   spike_cnt;
   logic             overrun;

   fc1_lif_neuron_layer #(
      .WIDTH(W), .FRAC(17), .NEURONS(N), .BETA(24'h10000), .VTH(24'h20000), .CNT_W(C)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .cur_in(cur_in), .clear_mem(clear_mem),
      .busy(busy), .spike_valid(spike_valid), .spikes(spikes), .v_mem(v_mem),
      .spike_cnt(spike_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int             due;
      logic [N-1:0]   spk;
      logic [W*N-1:0] v;
      logic [C*N-1:0] c;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   longint       mv[N];
   int           mc[N];
   logic [N-1:0] mspk = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && spike_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_spike_valid: observed at cycle %0d, required none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (cyc !== e.due) begin
               errors++;
               $display("FAIL latency: got cycle %0d, expected %0d", cyc, e.due);
            end
            checks++;
            if (spikes !== e.spk) begin
               errors++;
               $display("FAIL spikes: got %h, expected %h", spikes, e.spk);
            end
            checks++;
            if (v_mem !== e.v) begin
               errors++;
               $display("FAIL v_mem: got %h, expected %h", v_mem, e.v);
            end
            checks++;
            if (spike_cnt !== e.c) begin
               errors++;
               $display("FAIL spike_cnt: got %h, expected %h", spike_cnt, e.c);
            end
         end
      end
   end

   function automatic logic [W*N-1:0] fill(input logic [W-1:0] val);
      logic [W*N-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = val;
      return r;
   endfunction

   function automatic logic [W*N-1:0] rand_vec();
      logic [W*N-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         mv[k] = 0;
         mc[k] = 0;
      end
      mspk = '0;
   endtask

   task automatic model_step(input logic [W*N-1:0] cur);
      for (int k = 0; k < N; k++) begin
         longint c, p, s;
         c = longint'($signed(cur[k*W +: W]));
         p = mv[k] * 64'sd65536;
         s = (p >>> 17) + c;
         if (s > 64'sd8388607) s = 64'sd8388607;
         if (s < -64'sd8388608) s = -64'sd8388608;
         if (s >= 64'sd131072) begin
            mspk[k] = 1'b1;
            s = s - 64'sd131072;
            if (mc[k] < 255) mc[k]++;
         end else begin
            mspk[k] = 1'b0;
         end
         mv[k] = s;
      end
   endtask

   function automatic exp_t snapshot(input int due);
      exp_t e;
      e.due = due;
      e.spk = mspk;
      for (int k = 0; k < N; k++) begin
         e.v[k*W +: W] = mv[k][W-1:0];
         e.c[k*C +: C] = mc[k][C-1:0];
      end
      return e;
   endfunction

   task automatic pulse_clear();
      @(negedge clk);
      clear_mem = 1'b1;
      model_clear();
      @(negedge clk);
      clear_mem = 1'b0;
   endtask

   // One timestep; optional same-cycle clear and an extra in_valid pulse at cycle t0+pulse_at.
   task automatic run_step(input logic [W*N-1:0] cur, input bit with_clear, input int pulse_at,
                           input logic [W*N-1:0] pulse_cur);
      int t0;
      @(negedge clk);
      if (with_clear) model_clear();
      cur_in    = cur;
      in_valid  = 1'b1;
      clear_mem = with_clear;
      t0        = cyc;
      model_step(cur);
      sb.push_back(snapshot(t0 + N + 1));
      @(negedge clk);
      in_valid  = 1'b0;
      clear_mem = 1'b0;
      cur_in    = rand_vec();
      for (int i = 1; i <= N; i++) begin
         if (i == pulse_at) begin
            in_valid = 1'b1;
            cur_in   = pulse_cur;
         end
         @(negedge clk);
         in_valid = 1'b0;
         cur_in   = rand_vec();
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_spike_valid: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, spike_valid, overrun} !== 3'b000 || spikes !== '0 || v_mem !== '0 || spike_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: busy/sv/ovr=%b%b%b spikes=%h, expected all zero",
                  busy, spike_valid, overrun, spikes);
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_fire_all();
      pulse_clear();
      run_step(fill(24'h30000), 1'b0, 0, '0);
      checks++;
      if (spikes !== 20'hFFFFF || v_mem !== fill(24'h10000) || spike_cnt !== {N{8'h01}}) begin
         errors++;
         $display("FAIL fire_all: spikes=%h cnt=%h, expected FFFFF / all 01", spikes, spike_cnt);
      end
   endtask

   task automatic test_leak_no_fire();
      run_step(fill(24'h08000), 1'b0, 0, '0);
      checks++;
      if (spikes !== '0 || v_mem !== fill(24'h10000) || spike_cnt !== {N{8'h01}}) begin
         errors++;
         $display("FAIL leak_no_fire: spikes=%h cnt=%h, expected 0 / all 01", spikes, spike_cnt);
      end
   endtask

   task automatic test_clear_capture();
      run_step(fill(24'h08000), 1'b1, 0, '0);
      checks++;
      if (v_mem !== fill(24'h08000) || spike_cnt !== '0) begin
         errors++;
         $display("FAIL clear_capture: cnt=%h, expected v=008000 each and cnt 0", spike_cnt);
      end
   endtask

   task automatic test_neg_saturate();
      pulse_clear();
      for (int s = 0; s < 10; s++) begin
         run_step(fill(24'h800000), 1'b0, 0, '0);
         checks++;
         if (v_mem !== fill(24'h800000) || spikes !== '0) begin
            errors++;
            $display("FAIL neg_saturate step %0d: spikes=%h, expected v=800000 each and no spikes",
                     s, spikes);
         end
      end
   endtask

   task automatic test_overrun();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_initial: got %b, expected 0", overrun);
      end
      pulse_clear();
      run_step(fill(24'h30000), 1'b0, 5, fill(24'h7FFFFF));
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b, expected 1", overrun);
      end
   endtask

   task automatic test_clear_mid();
      @(negedge clk);
      cur_in   = fill(24'h30000);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i <= N + 3; i++) begin
         clear_mem = (i == 8);
         @(negedge clk);
         clear_mem = 1'b0;
         if (i == 8) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL clear_mid_busy: got %b, expected 0", busy);
            end
         end
      end
      model_clear();
      checks++;
      if (v_mem !== '0 || spike_cnt !== '0 || spikes !== '0) begin
         errors++;
         $display("FAIL clear_mid_zero: spikes=%h cnt=%h, expected 0", spikes, spike_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 6; s++) begin
         logic [W*N-1:0] r;
         for (int k = 0; k < N; k++)
            r[k*W +: W] = W'(int'($urandom_range(0, 393216)) - 196608);
         run_step(r, 1'b0, 0, '0);
      end
   endtask

   task automatic test_cnt_saturate_and_reset();
      logic [W*N-1:0] cur;
      logic [C*N-1:0] expc;
      pulse_clear();
      cur = '0;
      cur[3*W +: W] = 24'h40000;
      for (int s = 0; s < 300; s++) run_step(cur, 1'b0, 0, '0);
      expc = '0;
      expc[3*C +: C] = 8'hFF;
      checks++;
      if (spike_cnt !== expc) begin
         errors++;
         $display("FAIL cnt_saturate: got %h, expected %h", spike_cnt, expc);
      end
      @(negedge clk);
      cur_in   = cur;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({busy, spike_valid, overrun} !== 3'b000 || spikes !== '0 || v_mem !== '0 || spike_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset: busy/sv/ovr=%b%b%b cnt=%h, expected all zero",
                  busy, spike_valid, overrun, spike_cnt);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      repeat (N + 5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || v_mem !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b, expected 0 and v_mem 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_fire_all();
      test_leak_no_fire();
      test_clear_capture();
      test_neg_saturate();
      test_overrun();
      test_clear_mid();
      test_back_to_back();
      test_cnt_saturate_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
